// File: rtl/shaped_traffic_injector.sv
// Multi-queue AXI-Stream packet source: round-robin queue selection, FCP credit
// gating, token-bucket shaping, fixed or sweeping packet lengths, statistics.
module shaped_traffic_injector #(
  parameter int QUEUE_INDEX_WIDTH = 4,
  parameter int DATA_WIDTH        = 64,
  parameter int MIN_PKT_BYTES     = 64,
  parameter int MAX_PKT_BYTES     = 256,
  parameter int LEN_MODE          = 0,
  parameter int TOKEN_WIDTH       = 24,
  parameter bit INIT_QUEUE_EN     = 1'b1,
  parameter bit IGNORE_FCP_MODE   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         cfg_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] cfg_queue_idx,
  input  logic                         stop_cmd_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] stop_queue_idx,
  input  logic                         shape_en,
  input  logic [15:0]                  rate_inc,
  input  logic [TOKEN_WIDTH-1:0]       bucket_max,
  input  logic                         fcp_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  input  logic [31:0]                  fcp_fccl,
  output logic [DATA_WIDTH-1:0]        m_axis_pkt_tdata,
  output logic                         m_axis_pkt_tvalid,
  output logic                         m_axis_pkt_tlast,
  output logic [DATA_WIDTH/8-1:0]      m_axis_pkt_tkeep,
  input  logic                         m_axis_pkt_tready,
  output logic                         busy,
  input  logic [QUEUE_INDEX_WIDTH-1:0] stat_queue_idx,
  output logic [31:0]                  stat_queue_pkt_count,
  output logic [63:0]                  tx_pkt_count,
  output logic [63:0]                  tx_byte_count,
  output logic [1:0]                   o_dbg_state
);
  localparam int NQ    = 1 << QUEUE_INDEX_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = ((TOKEN_WIDTH > 16) ? TOKEN_WIDTH : 16) + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARB = 2'd1, ST_SEND = 2'd2} state_t;

  state_t                       r_state;
  logic [NQ-1:0]                r_queue_en;
  logic [31:0]                  r_fccl    [NQ];
  logic [31:0]                  r_tx_pkts [NQ];
  logic [TOKEN_WIDTH-1:0]       r_bucket;
  logic [15:0]                  r_cur_len;
  logic [15:0]                  r_len;
  logic [QUEUE_INDEX_WIDTH-1:0] r_rr_ptr;
  logic [QUEUE_INDEX_WIDTH-1:0] r_queue;
  logic [31:0]                  r_seq;
  logic [15:0]                  r_beat;
  logic [15:0]                  r_last_beat;
  logic [DATA_WIDTH-1:0]        r_tdata;
  logic [BYTES-1:0]             r_tkeep;
  logic                         r_tvalid;
  logic                         r_tlast;
  logic [31:0]                  r_stat;
  logic [63:0]                  r_tx_pkt_count;
  logic [63:0]                  r_tx_byte_count;

  logic [NQ-1:0]                w_elig;
  logic                         w_found;
  logic [QUEUE_INDEX_WIDTH-1:0] w_pick;
  logic                         w_bucket_ok;
  logic                         w_launch;
  logic [15:0]                  w_debit;
  logic [CW-1:0]                w_bucket_sum;
  logic [TOKEN_WIDTH-1:0]       w_bucket_next;
  logic [16:0]                  w_nbeats;
  logic [15:0]                  w_last_idx;
  logic                         w_accept;

  // Beat 0 carries the header; later beats carry the low byte of each packet offset.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [15:0] beat,
      input logic [15:0] len, input logic [QUEUE_INDEX_WIDTH-1:0] q, input logic [31:0] seq);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    if (beat == 16'd0) begin
      d[63:0] = {16'(q), len, seq};
    end else begin
      for (int j = 0; j < BYTES; j++) begin
        d[8*j +: 8] = 8'((beat << BSH) + 16'(j));
      end
    end
    return d;
  endfunction

  function automatic logic [BYTES-1:0] beat_keep(input logic is_last, input logic [15:0] len);
    logic [BYTES-1:0] k;
    logic [15:0]      rem;
    rem = len & 16'(BYTES - 1);
    for (int j = 0; j < BYTES; j++) begin
      k[j] = !is_last || (rem == 16'd0) || (16'(j) < rem);
    end
    return k;
  endfunction

  always_comb begin
    w_elig = '0;
    for (int q = 0; q < NQ; q++) begin
      w_elig[q] = r_queue_en[q] &&
                  (IGNORE_FCP_MODE || ($signed(r_fccl[q] - r_tx_pkts[q]) > 0));
    end
  end

  // Search starts one past the last winner; i == NQ wraps back to r_rr_ptr itself.
  always_comb begin
    logic [QUEUE_INDEX_WIDTH-1:0] v_cand;
    v_cand  = '0;
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int i = 1; i <= NQ; i++) begin
      v_cand = r_rr_ptr + i[QUEUE_INDEX_WIDTH-1:0];
      if (!w_found && w_elig[v_cand]) begin
        w_found = 1'b1;
        w_pick  = v_cand;
      end
    end
  end

  assign w_bucket_ok   = !shape_en || (CW'(r_bucket) >= CW'(r_cur_len));
  assign w_launch      = (r_state == ST_ARB) && w_found && w_bucket_ok;
  assign w_debit       = (w_launch && shape_en) ? r_cur_len : 16'd0;
  assign w_bucket_sum  = CW'(r_bucket) - CW'(w_debit) + CW'(rate_inc);
  assign w_bucket_next = (w_bucket_sum > CW'(bucket_max)) ? bucket_max
                                                          : w_bucket_sum[TOKEN_WIDTH-1:0];
  assign w_nbeats      = (17'(r_cur_len) + 17'(BYTES - 1)) >> BSH;
  assign w_last_idx    = 16'(w_nbeats - 17'd1);

  // Handshake: a beat transfers on a rising edge with tvalid & tready both high;
  // once tvalid is raised, tdata/tkeep/tlast hold until that transfer happens.
  assign w_accept = r_tvalid && m_axis_pkt_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_queue_en      <= {NQ{INIT_QUEUE_EN}};
      for (int q = 0; q < NQ; q++) begin
        r_fccl[q]    <= '0;
        r_tx_pkts[q] <= '0;
      end
      r_bucket        <= '0;
      r_cur_len       <= 16'(MIN_PKT_BYTES);
      r_len           <= '0;
      r_rr_ptr        <= '0;
      r_queue         <= '0;
      r_seq           <= '0;
      r_beat          <= '0;
      r_last_beat     <= '0;
      r_tdata         <= '0;
      r_tkeep         <= '0;
      r_tvalid        <= 1'b0;
      r_tlast         <= 1'b0;
      r_stat          <= '0;
      r_tx_pkt_count  <= '0;
      r_tx_byte_count <= '0;
    end else begin
      // Stop is applied after cfg so it wins on a same-queue collision.
      if (cfg_valid)      r_queue_en[cfg_queue_idx]  <= 1'b1;
      if (stop_cmd_valid) r_queue_en[stop_queue_idx] <= 1'b0;
      if (fcp_valid)      r_fccl[fcp_vc]             <= fcp_fccl;
      if (shape_en)       r_bucket                   <= w_bucket_next;
      r_stat <= r_tx_pkts[stat_queue_idx];

      case (r_state)
        ST_IDLE: if (enable) r_state <= ST_ARB;
        ST_ARB: begin
          if (w_launch) begin
            r_queue     <= w_pick;
            r_rr_ptr    <= w_pick;
            r_len       <= r_cur_len;
            r_beat      <= '0;
            r_last_beat <= w_last_idx;
            r_tdata     <= beat_data(16'd0, r_cur_len, w_pick, r_seq);
            r_tkeep     <= beat_keep(w_last_idx == 16'd0, r_cur_len);
            r_tlast     <= (w_last_idx == 16'd0);
            r_tvalid    <= 1'b1;
            r_state     <= ST_SEND;
          end else if (!enable) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (r_tlast) begin
              r_tvalid           <= 1'b0;
              r_tlast            <= 1'b0;
              r_tkeep            <= '0;
              r_tdata            <= '0;
              r_tx_pkts[r_queue] <= r_tx_pkts[r_queue] + 32'd1;
              r_seq              <= r_seq + 32'd1;
              r_tx_pkt_count     <= r_tx_pkt_count + 64'd1;
              r_tx_byte_count    <= r_tx_byte_count + 64'(r_len);
              if (LEN_MODE != 0) begin
                r_cur_len <= (r_cur_len >= 16'(MAX_PKT_BYTES)) ? 16'(MIN_PKT_BYTES)
                                                               : r_cur_len + 16'd1;
              end
              r_state <= enable ? ST_ARB : ST_IDLE;
            end else begin
              r_beat  <= r_beat + 16'd1;
              r_tdata <= beat_data(r_beat + 16'd1, r_len, r_queue, r_seq);
              r_tkeep <= beat_keep((r_beat + 16'd1) == r_last_beat, r_len);
              r_tlast <= ((r_beat + 16'd1) == r_last_beat);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_pkt_tdata     = r_tdata;
  assign m_axis_pkt_tvalid    = r_tvalid;
  assign m_axis_pkt_tlast     = r_tlast;
  assign m_axis_pkt_tkeep     = r_tkeep;
  assign busy                 = (r_state != ST_IDLE);
  assign stat_queue_pkt_count = r_stat;
  assign tx_pkt_count         = r_tx_pkt_count;
  assign tx_byte_count        = r_tx_byte_count;
  assign o_dbg_state          = r_state;
endmodule
